apb_conv_sequencer: RTL and testbench
=====================================

// Module: apb_conv_sequencer
// PURPOSE
//  APB requester (bus master) that drives the conv block's APB register file for one layer.
//  A start handshake latches flen/in_ch/out_ch; the block then writes the config registers,
//  issues each command phase, polls the matching done register, and pulses done at the end.
//  Sits between the layer-control logic and the conv block's PCLK-domain APB port.
// PARAMETERS
//  POLL_GAP    default 4     idle bus cycles (PSEL=0) between a failed poll and its retry.
//  MAX_POLLS   default 1024  polls allowed per phase before abort (only with POLL_TIMEOUT_EN).
// PORTS
//  PCLK        in   1   clock; all logic on posedge
//  PRESET      in   1   synchronous reset, active-high
//  start       in   1   request; accepted only when busy=0
//  cfg_flen    in   6   feature-map length, latched on accept
//  cfg_in_ch   in   9   input channels, latched on accept
//  cfg_out_ch  in   9   output channels, latched on accept
//  busy        out  1   high from the cycle after accept until done
//  done        out  1   one-cycle pulse at sequence end
//  err         out  1   sticky abort flag, cleared on next accept (0 without macro)
//  phase       out  3   current command code being run (0 when idle)
//  PADDR       out  32  APB address
//  PSEL        out  1   APB select
//  PENABLE     out  1   APB enable
//  PWRITE      out  1   APB direction, 1=write
//  PWDATA      out  32  APB write data
//  PRDATA      in   32  APB read data, sampled in ACCESS cycle
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, step=0; applies on the next PCLK edge even mid-transfer.
//  FSM: IDLE -> SETUP -> ACCESS -> (next SETUP | GAP | FIN); GAP -> SETUP; FIN -> IDLE.
//  Transfer: SETUP PSEL=1,PENABLE=0; ACCESS PSEL=1,PENABLE=1; PADDR/PWRITE/PWDATA stable
//   across both; no PREADY, no wait states. Back-to-back transfers allowed (no idle cycle).
//  Steps 0..11: W 0x04=in_ch; W 0x08=out_ch; W 0x0c=flen; W 0x00=1; R 0x20;
//   W 0x00=2; R 0x24; W 0x00=3; R 0x28; W 0x00=4; R 0x2c; W 0x00=0.
//  Write data zero-extended to 32 bits. PWDATA=0 on reads; PADDR/PWDATA=0 when PSEL=0.
//  Poll: PRDATA[0]=1 -> advance; else GAP for POLL_GAP cycles then re-issue same read;
//   POLL_GAP=0 -> retry SETUP directly after ACCESS.
//  phase = command value of the most recent command write (1..4), 0 in IDLE/after step 11.
//  Latency: start high in IDLE at cycle 0 -> SETUP step 0 at cycle 1; with no retries
//   done pulses at cycle 25 (12 transfers x 2 cycles + FIN), busy falls with done.
//  start while busy is ignored; start held high re-triggers on the cycle after FIN.
//  Simultaneous start and PRESET: reset wins, start dropped.
// CONFIGURATION
//  POLL_TIMEOUT_EN defined: per-phase poll counter (cleared on each command write);
//   on reaching MAX_POLLS failed polls, jump to step 11 (write command=0), set err=1,
//   then FIN/done as normal.
//  POLL_TIMEOUT_EN undefined: polls retried forever, err tied 0, no counter logic.
// STRUCTURE
//  Package apb_conv_pkg: register address localparams (0x00,0x04,0x08,0x0c,0x20-0x2c),
//   command codes CMD_IDLE=0..CMD_CONV=4, FSM state enum, NUM_STEPS=12, step record typedef
//   {addr, write, data_sel}.
//  Sub-module apb_conv_step_rom: combinational step index -> step record.
// TESTING
//  Reset then start, in_ch=3, out_ch=16, flen=32, slave done regs=1 -> 12 transfers in
//   order above, PWDATA 3/16/32/1/2/3/4/0, done at cycle 25, err=0.
//  Slave 0x24 returns 0 for 3 polls, POLL_GAP=4 -> 4 reads of 0x24, 4 idle cycles
//   between each, phase=2 throughout, then W 0x00=3.
//  start pulsed again while busy -> ignored; latched cfg unchanged; single done pulse.
//  PRESET asserted during ACCESS of step 5 -> next cycle PSEL=PENABLE=0, busy=0, phase=0;
//   new start restarts from step 0.
//  POLL_TIMEOUT_EN, MAX_POLLS=8, 0x2c stuck 0 -> 8 reads, W 0x00=0, done with err=1;
//   next start clears err.
//  Protocol checker on all runs: PENABLE only after SETUP, PADDR/PWDATA stable in ACCESS.

Source files
------------

// File: rtl/apb_conv_pkg.sv
// rtl/apb_conv_pkg.sv - shared register map, command codes, FSM states and step records
package apb_conv_pkg;

    localparam logic [31:0] REG_CMD       = 32'h00;
    localparam logic [31:0] REG_IN_CH     = 32'h04;
    localparam logic [31:0] REG_OUT_CH    = 32'h08;
    localparam logic [31:0] REG_FLEN      = 32'h0c;
    localparam logic [31:0] REG_DONE_W    = 32'h20;
    localparam logic [31:0] REG_DONE_IN   = 32'h24;
    localparam logic [31:0] REG_DONE_ACC  = 32'h28;
    localparam logic [31:0] REG_DONE_CONV = 32'h2c;

    localparam logic [2:0] CMD_IDLE    = 3'd0;
    localparam logic [2:0] CMD_LOAD_W  = 3'd1;
    localparam logic [2:0] CMD_LOAD_IN = 3'd2;
    localparam logic [2:0] CMD_ACC     = 3'd3;
    localparam logic [2:0] CMD_CONV    = 3'd4;

    localparam int NUM_STEPS = 12;
    localparam int STEP_W    = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_ACCESS = 3'd2,
        ST_GAP    = 3'd3,
        ST_FIN    = 3'd4
    } state_e;

    // Command selectors share their encoding with the command code they write.
    typedef enum logic [2:0] {
        DS_CMD0   = 3'd0,
        DS_CMD1   = 3'd1,
        DS_CMD2   = 3'd2,
        DS_CMD3   = 3'd3,
        DS_CMD4   = 3'd4,
        DS_IN_CH  = 3'd5,
        DS_OUT_CH = 3'd6,
        DS_FLEN   = 3'd7
    } data_sel_e;

    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        data_sel_e   data_sel;
    } step_t;

    function automatic step_t mk_step(logic [31:0] a, logic w, data_sel_e ds);
        step_t s;
        s.addr     = a;
        s.write    = w;
        s.data_sel = ds;
        return s;
    endfunction

endpackage

// File: rtl/apb_conv_step_rom.sv
// rtl/apb_conv_step_rom.sv - step index to bus transfer descriptor lookup
import apb_conv_pkg::*;

module apb_conv_step_rom (
    input  logic [STEP_W-1:0] step_idx,
    output step_t             step
);

    // Fixed layer program: config writes, then command/poll pairs, then command clear.
    always_comb begin
        case (step_idx)
            4'd0:    step = mk_step(REG_IN_CH,     1'b1, DS_IN_CH);
            4'd1:    step = mk_step(REG_OUT_CH,    1'b1, DS_OUT_CH);
            4'd2:    step = mk_step(REG_FLEN,      1'b1, DS_FLEN);
            4'd3:    step = mk_step(REG_CMD,       1'b1, DS_CMD1);
            4'd4:    step = mk_step(REG_DONE_W,    1'b0, DS_CMD0);
            4'd5:    step = mk_step(REG_CMD,       1'b1, DS_CMD2);
            4'd6:    step = mk_step(REG_DONE_IN,   1'b0, DS_CMD0);
            4'd7:    step = mk_step(REG_CMD,       1'b1, DS_CMD3);
            4'd8:    step = mk_step(REG_DONE_ACC,  1'b0, DS_CMD0);
            4'd9:    step = mk_step(REG_CMD,       1'b1, DS_CMD4);
            4'd10:   step = mk_step(REG_DONE_CONV, 1'b0, DS_CMD0);
            default: step = mk_step(REG_CMD,       1'b1, DS_CMD0);
        endcase
    end

endmodule

// File: rtl/apb_conv_sequencer.sv
// rtl/apb_conv_sequencer.sv - APB requester running one conv layer; POLL_TIMEOUT_EN adds poll abort
import apb_conv_pkg::*;

module apb_conv_sequencer #(
    parameter int POLL_GAP  = 4,
    parameter int MAX_POLLS = 1024
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic        start,
    input  logic [5:0]  cfg_flen,
    input  logic [8:0]  cfg_in_ch,
    input  logic [8:0]  cfg_out_ch,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [2:0]  phase,
    output logic [31:0] PADDR,
    output logic        PSEL,
    output logic        PENABLE,
    output logic        PWRITE,
    output logic [31:0] PWDATA,
    input  logic [31:0] PRDATA
);

    state_e              state_q, state_d;
    logic [STEP_W-1:0]   step_q, step_d;
    logic [15:0]         gap_q, gap_d;
    logic [5:0]          flen_q, flen_d;
    logic [8:0]          in_ch_q, in_ch_d;
    logic [8:0]          out_ch_q, out_ch_d;
    logic [2:0]          phase_q, phase_d;
    step_t               cur;
    logic [31:0]         wdata;
    logic                accept;
    logic                is_cmd;
    logic                poll_fail;
    logic                timeout;
    logic                prdata_unused;

    apb_conv_step_rom u_rom (
        .step_idx (step_q),
        .step     (cur)
    );

    assign accept        = (state_q == ST_IDLE) && start;
    assign is_cmd        = cur.write && (cur.addr == REG_CMD);
    assign poll_fail     = (state_q == ST_ACCESS) && !cur.write && !PRDATA[0];
    assign prdata_unused = ^PRDATA[31:1];

`ifdef POLL_TIMEOUT_EN
    logic [15:0] polls_q, polls_d;
    logic        err_q, err_d;

    assign timeout = poll_fail && (polls_q == 16'(MAX_POLLS - 1));
    assign err     = err_q;

    // Failed polls per phase; restarts on each command write, abort is sticky until next accept
    always_comb begin
        polls_d = polls_q;
        err_d   = err_q;
        if (accept) begin
            polls_d = '0;
            err_d   = 1'b0;
        end else if ((state_q == ST_ACCESS) && is_cmd) begin
            polls_d = '0;
        end else if (poll_fail) begin
            polls_d = polls_q + 16'd1;
            if (timeout) err_d = 1'b1;
        end
    end

    // Poll counter and abort flag registers
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            polls_q <= '0;
            err_q   <= 1'b0;
        end else begin
            polls_q <= polls_d;
            err_q   <= err_d;
        end
    end
`else
    logic [15:0] max_polls_unused;
    assign max_polls_unused = 16'(MAX_POLLS);
    assign timeout          = 1'b0;
    assign err              = 1'b0;
`endif

    // Next state: walk the step program, retrying failed polls after the idle gap
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        gap_d   = gap_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_SETUP;
                    step_d  = '0;
                end
            end
            ST_SETUP: state_d = ST_ACCESS;
            ST_ACCESS: begin
                if (timeout) begin
                    step_d  = STEP_W'(NUM_STEPS - 1);
                    state_d = ST_SETUP;
                end else if (poll_fail) begin
                    if (POLL_GAP == 0) begin
                        state_d = ST_SETUP;
                    end else begin
                        state_d = ST_GAP;
                        gap_d   = '0;
                    end
                end else if (step_q == STEP_W'(NUM_STEPS - 1)) begin
                    state_d = ST_FIN;
                end else begin
                    step_d  = step_q + 1'b1;
                    state_d = ST_SETUP;
                end
            end
            ST_GAP: begin
                if (gap_q == 16'(POLL_GAP - 1)) state_d = ST_SETUP;
                else                             gap_d   = gap_q + 16'd1;
            end
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Layer config is captured on accept; phase tracks the last command written
    always_comb begin
        flen_d   = flen_q;
        in_ch_d  = in_ch_q;
        out_ch_d = out_ch_q;
        phase_d  = phase_q;
        if (accept) begin
            flen_d   = cfg_flen;
            in_ch_d  = cfg_in_ch;
            out_ch_d = cfg_out_ch;
            phase_d  = CMD_IDLE;
        end else if ((state_q == ST_ACCESS) && is_cmd) begin
            phase_d = 3'(cur.data_sel);
        end
    end

    // State and datapath registers
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q  <= ST_IDLE;
            step_q   <= '0;
            gap_q    <= '0;
            flen_q   <= '0;
            in_ch_q  <= '0;
            out_ch_q <= '0;
            phase_q  <= '0;
        end else begin
            state_q  <= state_d;
            step_q   <= step_d;
            gap_q    <= gap_d;
            flen_q   <= flen_d;
            in_ch_q  <= in_ch_d;
            out_ch_q <= out_ch_d;
            phase_q  <= phase_d;
        end
    end

    // Bus outputs: address/data only while selected, held across SETUP and ACCESS
    always_comb begin
        case (cur.data_sel)
            DS_IN_CH:  wdata = {23'd0, in_ch_q};
            DS_OUT_CH: wdata = {23'd0, out_ch_q};
            DS_FLEN:   wdata = {26'd0, flen_q};
            default:   wdata = {29'd0, cur.data_sel};
        endcase
        PSEL    = 1'b0;
        PENABLE = 1'b0;
        PWRITE  = 1'b0;
        PADDR   = '0;
        PWDATA  = '0;
        if ((state_q == ST_SETUP) || (state_q == ST_ACCESS)) begin
            PSEL    = 1'b1;
            PENABLE = (state_q == ST_ACCESS);
            PWRITE  = cur.write;
            PADDR   = cur.addr;
            PWDATA  = cur.write ? wdata : 32'd0;
        end
        busy  = (state_q == ST_SETUP) || (state_q == ST_ACCESS) || (state_q == ST_GAP);
        done  = (state_q == ST_FIN);
        phase = phase_q;
    end

endmodule

// File: tb/tb_apb_conv_sequencer.sv
// tb/tb_apb_conv_sequencer.sv - scoreboard bench for apb_conv_sequencer with randomized layers
module tb_apb_conv_sequencer;

    localparam int POLL_GAP = 4;
`ifdef POLL_TIMEOUT_EN
    localparam int MAX_POLLS  = 8;
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam int MAX_POLLS  = 1024;
    localparam bit TIMEOUT_EN = 1'b0;
`endif

    logic        PCLK = 1'b0;
    logic        PRESET;
    logic        start;
    logic [5:0]  cfg_flen;
    logic [8:0]  cfg_in_ch;
    logic [8:0]  cfg_out_ch;
    logic        busy, done, err;
    logic [2:0]  phase;
    logic [31:0] PADDR, PWDATA, PRDATA;
    logic        PSEL, PENABLE, PWRITE;

    apb_conv_sequencer #(.POLL_GAP(POLL_GAP), .MAX_POLLS(MAX_POLLS)) dut (
        .PCLK(PCLK), .PRESET(PRESET), .start(start),
        .cfg_flen(cfg_flen), .cfg_in_ch(cfg_in_ch), .cfg_out_ch(cfg_out_ch),
        .busy(busy), .done(done), .err(err), .phase(phase),
        .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PWDATA(PWDATA), .PRDATA(PRDATA)
    );

    always #5 PCLK = ~PCLK;

    int cyc = 0;
    always @(posedge PCLK) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [31:0] data;
        int          ph;
        int          cyc;
    } xfer_t;
    typedef struct {
        int   cyc;
        logic err;
    } done_t;

    xfer_t exp_q[$];
    done_t done_q[$];
    int    fails[4];
    int    checks = 0;
    int    passes = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, req, cyc);
    endtask

    task automatic push_x(inout int t, input logic [31:0] a, input logic w, input logic [31:0] d, input int ph);
        xfer_t x;
        x.addr = a; x.wr = w; x.data = d; x.ph = ph; x.cyc = t;
        exp_q.push_back(x);
        t += 2;
    endtask

    // Expected transfers and done for one layer accepted in cycle acc.
    task automatic model_run(input int acc, input logic [8:0] ic, input logic [8:0] oc, input logic [5:0] fl);
        int    t;
        logic  ab;
        done_t dn;
        t  = acc + 2;
        ab = 1'b0;
        push_x(t, 32'h04, 1'b1, 32'(ic), -1);
        push_x(t, 32'h08, 1'b1, 32'(oc), -1);
        push_x(t, 32'h0c, 1'b1, 32'(fl), -1);
        for (int k = 1; k <= 4 && !ab; k++) begin
            push_x(t, 32'h00, 1'b1, 32'(k), -1);
            if (TIMEOUT_EN && fails[k-1] >= MAX_POLLS) begin
                for (int j = 0; j < MAX_POLLS; j++) begin
                    push_x(t, 32'h1c + 32'(4*k), 1'b0, 32'd0, k);
                    if (j < MAX_POLLS - 1) t += POLL_GAP;
                end
                ab = 1'b1;
            end else begin
                for (int j = 0; j < fails[k-1]; j++) begin
                    push_x(t, 32'h1c + 32'(4*k), 1'b0, 32'd0, k);
                    t += POLL_GAP;
                end
                push_x(t, 32'h1c + 32'(4*k), 1'b0, 32'd0, k);
            end
        end
        push_x(t, 32'h00, 1'b1, 32'd0, -1);
        dn.cyc = t - 1;
        dn.err = ab;
        done_q.push_back(dn);
    endtask

    // Slave: each done register reads 0 for fails[i] polls of a layer, then 1.
    initial begin
        int served[4];
        int idx;
        logic [31:0] r;
        for (int i = 0; i < 4; i++) served[i] = 0;
        PRDATA = 32'd0;
        forever begin
            @(negedge PCLK);
            r = $urandom;
            PRDATA = {r[31:1], 1'b1};
            if (PSEL && PENABLE && PWRITE && PADDR == 32'h04)
                for (int i = 0; i < 4; i++) served[i] = 0;
            if (PSEL && PENABLE && !PWRITE && PADDR >= 32'h20 && PADDR <= 32'h2c) begin
                idx = int'((PADDR - 32'h20) >> 2);
                if (served[idx] < fails[idx]) PRDATA = {r[31:1], 1'b0};
                served[idx]++;
            end
        end
    end

    // Monitor: protocol rules plus scoreboard pops on ACCESS and done.
    initial begin
        logic        p_sel, p_en, p_wr;
        logic [31:0] p_addr, p_data;
        xfer_t       e;
        done_t       d;
        p_sel = 1'b0; p_en = 1'b0; p_wr = 1'b0; p_addr = '0; p_data = '0;
        forever begin
            @(negedge PCLK);
            if (!PRESET) begin
                if (PSEL && PENABLE) begin
                    chk("penable_after_setup", {30'd0, p_sel, p_en}, 32'd2);
                    chk("paddr_stable", PADDR, p_addr);
                    chk("pwdata_stable", PWDATA, p_data);
                    chk("pwrite_stable", {31'd0, PWRITE}, {31'd0, p_wr});
                    chk("busy_in_access", {31'd0, busy}, 32'd1);
                    if (exp_q.size() == 0) begin
                        checks++;
                        $display("FAIL unexpected_xfer: addr 0x%0h at cycle %0d, required none", PADDR, cyc);
                    end else begin
                        e = exp_q.pop_front();
                        chk("xfer_addr", PADDR, e.addr);
                        chk("xfer_write", {31'd0, PWRITE}, {31'd0, e.wr});
                        chk("xfer_wdata", PWDATA, e.data);
                        chk("xfer_cycle", cyc, e.cyc);
                        if (e.ph >= 0) chk("poll_phase", {29'd0, phase}, e.ph);
                    end
                end
                if (!PSEL) begin
                    chk("idle_paddr", PADDR, 32'd0);
                    chk("idle_pwdata", PWDATA, 32'd0);
                    chk("idle_penable", {31'd0, PENABLE}, 32'd0);
                end
                if (done) begin
                    if (done_q.size() == 0) begin
                        checks++;
                        $display("FAIL unexpected_done: done at cycle %0d, required none", cyc);
                    end else begin
                        d = done_q.pop_front();
                        chk("done_cycle", cyc, d.cyc);
                        chk("done_err", {31'd0, err}, {31'd0, d.err});
                        chk("done_busy", {31'd0, busy}, 32'd0);
                        chk("done_phase", {29'd0, phase}, 32'd0);
                    end
                end
            end
            p_sel = PSEL; p_en = PENABLE; p_wr = PWRITE; p_addr = PADDR; p_data = PWDATA;
        end
    end

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || done_q.size() != 0) && n < budget) begin
            @(negedge PCLK);
            n++;
        end
        if (exp_q.size() != 0 || done_q.size() != 0) begin
            checks++;
            $display("FAIL wait_idle: %0d transfers and %0d dones still pending, required 0",
                     exp_q.size(), done_q.size());
            exp_q.delete();
            done_q.delete();
        end
    endtask

    task automatic start_run(input logic [8:0] ic, input logic [8:0] oc, input logic [5:0] fl, output int acc);
        @(posedge PCLK); #1;
        cfg_in_ch = ic; cfg_out_ch = oc; cfg_flen = fl;
        start = 1'b1;
        acc = cyc;
        model_run(acc, ic, oc, fl);
        @(posedge PCLK); #1;
        start = 1'b0;
        cfg_in_ch = 9'($urandom); cfg_out_ch = 9'($urandom); cfg_flen = 6'($urandom);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, acc2, n;
        for (int i = 0; i < 4; i++) fails[i] = 0;
        PRESET = 1'b1; start = 1'b1;
        cfg_in_ch = 9'd5; cfg_out_ch = 9'd6; cfg_flen = 6'd7;

        // Reset with start held: reset wins
        repeat (3) @(posedge PCLK);
        @(negedge PCLK);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_err", {31'd0, err}, 32'd0);
        chk("reset_phase", {29'd0, phase}, 32'd0);
        chk("reset_psel", {31'd0, PSEL}, 32'd0);
        @(posedge PCLK); #1;
        PRESET = 1'b0; start = 1'b0;
        @(negedge PCLK);
        chk("start_dropped_busy", {31'd0, busy}, 32'd0);
        repeat (2) @(posedge PCLK);

        // Nominal layer, with an ignored start pulse while busy
        start_run(9'd3, 9'd16, 6'd32, acc);
        repeat (5) @(posedge PCLK);
        #1; start = 1'b1; cfg_in_ch = 9'd7; cfg_out_ch = 9'd9; cfg_flen = 6'd5;
        @(posedge PCLK); #1; start = 1'b0;
        wait_idle(200);

        // 0x24 not ready for three polls
        fails[1] = 3;
        start_run(9'd3, 9'd16, 6'd32, acc);
        wait_idle(300);
        fails[1] = 0;

        // start held high re-triggers after FIN
        @(posedge PCLK); #1;
        cfg_in_ch = 9'd100; cfg_out_ch = 9'd200; cfg_flen = 6'd63;
        start = 1'b1;
        acc = cyc;
        model_run(acc, 9'd100, 9'd200, 6'd63);
        acc2 = done_q[$].cyc + 1;
        model_run(acc2, 9'd100, 9'd200, 6'd63);
        n = 0;
        while (cyc < acc2 + 1 && n < 200) begin
            @(posedge PCLK); #1;
            n++;
        end
        start = 1'b0;
        wait_idle(300);

        // Reset during ACCESS of step 5, then restart
        start_run(9'd11, 9'd22, 6'd33, acc);
        n = 0;
        while (cyc < acc + 12 && n < 100) begin
            @(posedge PCLK); #1;
            n++;
        end
        PRESET = 1'b1;
        @(negedge PCLK);
        @(posedge PCLK); #1;
        PRESET = 1'b0;
        exp_q.delete();
        done_q.delete();
        @(negedge PCLK);
        chk("midreset_psel", {31'd0, PSEL}, 32'd0);
        chk("midreset_penable", {31'd0, PENABLE}, 32'd0);
        chk("midreset_busy", {31'd0, busy}, 32'd0);
        chk("midreset_phase", {29'd0, phase}, 32'd0);
        start_run(9'd12, 9'd23, 6'd34, acc);
        wait_idle(200);

        // Randomized layers and poll delays
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < 4; i++) fails[i] = $urandom_range(0, 3);
            start_run(9'($urandom), 9'($urandom), 6'($urandom), acc);
            wait_idle(500);
        end
        for (int i = 0; i < 4; i++) fails[i] = 0;

`ifdef POLL_TIMEOUT_EN
        // 0x2c never ready: abort after MAX_POLLS, then next accept clears err
        fails[3] = 100;
        start_run(9'd1, 9'd2, 6'd3, acc);
        wait_idle(500);
        @(negedge PCLK);
        chk("err_sticky", {31'd0, err}, 32'd1);
        fails[3] = 0;
        start_run(9'd4, 9'd5, 6'd6, acc);
        @(negedge PCLK);
        chk("err_cleared", {31'd0, err}, 32'd0);
        wait_idle(200);
`endif

        repeat (3) @(posedge PCLK);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
